// File: rtl/full_adder_pkg.sv
// Shared definitions for the full_adder block: default width, flag record, overflow helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package full_adder_pkg;

    // Default operand width; a wider datapath overrides WIDTH at instantiation.
    localparam int FA_DEFAULT_WIDTH = 1;

    // Status bits that travel with every registered sum.
    typedef struct packed {
        logic cout;  // carry out of bit WIDTH-1
        logic ovf;   // two's-complement overflow
    } fa_flags_t;

    // Signed overflow is the disagreement between the carry into the MSB cell
    // and the carry out of it.
    function automatic logic fa_signed_ovf(input logic c_into_msb, input logic c_out_msb);
        return c_into_msb ^ c_out_msb;
    endfunction

endpackage : full_adder_pkg

// File: rtl/full_adder_bit.sv
// Single-bit full-adder cell, purely combinational.
// Latency: 0 cycles (no state).
// Backpressure: none; output follows inputs.
//
// Ports:
//   a, b  - operand bits
//   cin   - carry in from the lower cell
//   sum   - a ^ b ^ cin
//   cout  - carry out to the next cell
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Propagate term is shared by the sum and the carry.
    logic prop;

    assign prop = a ^ b;
    assign sum  = prop ^ cin;
    assign cout = (a & b) | (cin & prop);

endmodule : full_adder_bit

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with registered sum, carry-out and signed overflow.
// Latency: 1 cycle from in_valid sample to out_valid; throughput 1 result/cycle.
// Backpressure: none; every sampled input yields exactly one out_valid cycle.
//
// Ports:
//   clk, rst_n          - rising-edge clock, asynchronous active-low reset
//   in_valid, a, b, cin - operands sampled when in_valid is high (legal WIDTH 1..64)
//   out_valid           - high for one cycle per accepted operand set
//   sum, cout, ovf      - registered result; held while out_valid is low
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // carry[i] is the carry into cell i; carry[WIDTH] is the final carry out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;
    fa_flags_t        flags_comb;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    fa_flags_t        flags_q,     flags_d;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_bit u_bit (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum_comb[i]),
            .cout (carry[i+1])
        );
    end

    // For WIDTH=1 carry[WIDTH-1] is cin, giving ovf = cout ^ cin.
    always_comb begin
        flags_comb      = '0;
        flags_comb.cout = carry[WIDTH];
        flags_comb.ovf  = fa_signed_ovf(carry[WIDTH-1], carry[WIDTH]);
    end

    // The result registers only load on in_valid, so anything (including X/Z)
    // on a/b/cin while idle never reaches the outputs.
    always_comb begin
        out_valid_d = in_valid;
        sum_d       = sum_q;
        flags_d     = flags_q;
        if (in_valid) begin
            sum_d   = sum_comb;
            flags_d = flags_comb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            flags_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            flags_q     <= flags_d;
        end
    end

    // Outputs come straight from flops; no input-to-output combinational path.
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = flags_q.cout;
    assign ovf       = flags_q.ovf;

endmodule : full_adder

// File: tb/tb_full_adder.sv
module tb_full_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // WIDTH=1 instance
    logic       v1, a1, b1, c1;
    logic       ov1, s1, co1, of1;
    // WIDTH=8 instance
    logic       v8, c8;
    logic [7:0] a8, b8;
    logic       ov8, co8, of8;
    logic [7:0] s8;
    // WIDTH=16 instance
    logic        v16, c16;
    logic [15:0] a16, b16;
    logic        ov16, co16, of16;
    logic [15:0] s16;

    full_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
        .out_valid(ov1), .sum(s1), .cout(co1), .ovf(of1)
    );
    full_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
        .out_valid(ov8), .sum(s8), .cout(co8), .ovf(of8)
    );
    full_adder #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .a(a16), .b(b16), .cin(c16),
        .out_valid(ov16), .sum(s16), .cout(co16), .ovf(of16)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned sum via plain integer addition; overflow by checking
    // whether the signed interpretation of a + b + cin leaves the w-bit range.
    // Returns {ovf, cout, sum[63:0]}.
    function automatic logic [65:0] ref_add(input int w, input longint unsigned a,
                                            input longint unsigned b, input bit cin);
        longint unsigned mask, tot;
        longint          sa, sb, s, hi, lo;
        logic            o, co;
        mask = (longint'(1) << w) - 1;
        tot  = (a & mask) + (b & mask) + longint'(cin);
        sa   = longint'(a & mask);
        sb   = longint'(b & mask);
        if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
        if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
        s    = sa + sb + longint'(cin);
        hi   = (longint'(1) << (w - 1)) - 1;
        lo   = -(longint'(1) << (w - 1));
        o    = (s > hi) || (s < lo);
        co   = (tot >> w) != 0;
        return {o, co, tot & mask};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Safety net: the stimulus is a fixed number of cycles, but never hang.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  sc_tab [8];
        logic        ovf_tab [8];
        logic [65:0] r;
        logic [7:0]  e_s8;
        logic        e_co8, e_of8;
        int          run;

        sc_tab  = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
        ovf_tab = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0;
        v1 = 0; a1 = 0; b1 = 0; c1 = 0;
        v8 = 0; a8 = '0; b8 = '0; c8 = 0;
        v16 = 0; a16 = '0; b16 = '0; c16 = 0;
        #1;
        // ---- reset state
        check("rst ov1", ov1, 0);
        check("rst s1/co1/of1", {s1, co1, of1}, 0);
        check("rst ov8", ov8, 0);
        check("rst s8", s8, 0);
        check("rst co8/of8", {co8, of8}, 0);
        check("rst ov16/s16", {ov16, s16, co16, of16}, 0);

        tick();
        tick();
        rst_n = 1'b1;

        // ---- WIDTH=1 exhaustive truth table
        for (int i = 0; i < 8; i++) begin
            {a1, b1, c1} = 3'(i);
            v1 = 1'b1;
            tick();
            check($sformatf("w1 vld %0d", i), ov1, 1);
            check($sformatf("w1 sum/cout %0d", i), {s1, co1}, sc_tab[i]);
            check($sformatf("w1 ovf %0d", i), of1, ovf_tab[i]);
        end
        v1 = 1'b0;
        tick();
        check("w1 vld drop", ov1, 0);

        // ---- WIDTH=8 carry ripple and signed overflow
        a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1; v8 = 1'b1;
        tick();
        check("w8 ripple", {ov8, co8, of8, s8}, {1'b1, 1'b1, 1'b0, 8'h00});
        a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0;
        tick();
        check("w8 ovf", {ov8, co8, of8, s8}, {1'b1, 1'b0, 1'b1, 8'h80});

        // ---- valid gating, including X on idle inputs
        a8 = 8'h03; b8 = 8'h04; c8 = 1'b0; v8 = 1'b1;
        tick();
        check("gate vld", ov8, 1);
        check("gate sum", s8, 8'h07);
        v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
        tick();
        check("gate vld off", ov8, 0);
        check("gate sum hold", s8, 8'h07);
        a8 = 'x; b8 = 'x; c8 = 'x;
        tick();
        check("gate x hold", {ov8, co8, of8, s8}, {1'b0, 1'b0, 1'b0, 8'h07});

        // ---- randomized WIDTH=8 traffic with random valid gaps
        e_s8 = 8'h07; e_co8 = 0; e_of8 = 0;
        for (int i = 0; i < 24; i++) begin
            logic vv;
            vv = ($urandom_range(3) != 0);
            v8 = vv;
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
            if (vv) begin
                r = ref_add(8, longint'(a8), longint'(b8), c8);
                e_s8 = r[7:0]; e_co8 = r[64]; e_of8 = r[65];
            end
            tick();
            check($sformatf("w8 rnd %0d", i), {ov8, co8, of8, s8}, {vv, e_co8, e_of8, e_s8});
        end

        // ---- asynchronous reset while out_valid is high
        a8 = 8'hC0; b8 = 8'h90; c8 = 1'b1; v8 = 1'b1;
        tick();
        check("pre-rst result", {ov8, co8, of8, s8}, {1'b1, 1'b1, 1'b1, 8'h51});
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst", {ov8, co8, of8, s8}, 0);
        tick();
        check("in-rst sample dropped", {ov8, s8}, 0);
        #2;
        rst_n = 1'b1;
        a8 = 8'h12; b8 = 8'h34; c8 = 1'b0; v8 = 1'b1;
        tick();
        check("post-rst first", {ov8, co8, of8, s8}, {1'b1, 1'b0, 1'b0, 8'h46});
        v8 = 1'b0;
        tick();
        check("post-rst single pulse", ov8, 0);

        // ---- back-to-back WIDTH=16 throughput
        run = 0;
        for (int i = 0; i < 16; i++) begin
            a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom); v16 = 1'b1;
            r = ref_add(16, longint'(a16), longint'(b16), c16);
            tick();
            if (ov16 === 1'b1) run++;
            check($sformatf("w16 b2b %0d", i), {ov16, co16, of16, s16},
                  {1'b1, r[64], r[65], r[15:0]});
        end
        v16 = 1'b0;
        tick();
        check("w16 run length", 17'(run), 17'd16);
        check("w16 vld drop", ov16, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_full_adder
